// File: rtl/mem_add_ctrl_pkg.sv
// mem_add_ctrl_pkg
// Purpose: shared definitions for the memory add controller. This package holds
//          the default word and address widths and the controller state
//          encoding. The controller imports it.
// Ports:   none (package)
package mem_add_ctrl_pkg;

  // Default geometry: 8-bit words in an 8-entry RAM.
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;

  // One operation walks through every state in this order and then returns
  // to IDLE.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_A  = 3'd1,
    RD_B  = 3'd2,
    CAP_B = 3'd3,
    WR    = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/mem_add_ctrl.sv
// mem_add_ctrl
// Purpose: reads two words from an external single-port synchronous RAM,
//          adds them as unsigned numbers and writes the low DATA_W bits of the
//          sum back to a third address. One operation takes 6 cycles from the
//          start request to the return to IDLE.
// Ports:
//   clk        - single clock; all state updates on its rising edge
//   rst        - synchronous active-low reset
//   start      - request one operation; sampled only while idle
//   addr1      - operand A address, latched when start is accepted
//   addr2      - operand B address, latched when start is accepted
//   dst        - write-back address, latched when start is accepted
//   mem_addr   - RAM address
//   mem_we     - RAM write enable
//   mem_wdata  - RAM write data
//   mem_rdata  - RAM read data, valid one cycle after the address is driven
//   busy       - high in every state except IDLE
//   done       - one-cycle pulse per completed operation
//   result     - last computed sum (low DATA_W bits)
//   carry      - bit DATA_W of the last unsigned sum
module mem_add_ctrl
  import mem_add_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [ADDR_W-1:0] dst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] a1_q, a1_d;
  logic [ADDR_W-1:0] a2_q, a2_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W:0]   sum_q, sum_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              carry_q, carry_d;

  // Next-state and output decode. Every output defaults to its idle value.
  // Each state then drives only what differs from that idle value.
  always_comb begin
    state_d   = state_q;
    a1_d      = a1_q;
    a2_d      = a2_q;
    dst_d     = dst_q;
    opa_d     = opa_q;
    sum_d     = sum_q;
    result_d  = result_q;
    carry_d   = carry_q;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    busy      = 1'b1;
    done      = 1'b0;

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          a1_d    = addr1;
          a2_d    = addr2;
          dst_d   = dst;
          state_d = RD_A;
        end
      end
      RD_A: begin
        mem_addr = a1_q;
        state_d  = RD_B;
      end
      RD_B: begin
        // The read data now belongs to the address issued in RD_A.
        mem_addr = a2_q;
        opa_d    = mem_rdata;
        state_d  = CAP_B;
      end
      CAP_B: begin
        // The read data now belongs to addr2. The extra top bit keeps the carry.
        sum_d   = {1'b0, opa_q} + {1'b0, mem_rdata};
        state_d = WR;
      end
      WR: begin
        // Gating with rst makes a reset during this cycle also cancel the
        // write that the RAM would otherwise commit at the same edge.
        mem_we    = rst;
        mem_addr  = dst_q;
        mem_wdata = sum_q[DATA_W-1:0];
        result_d  = sum_q[DATA_W-1:0];
        carry_d   = sum_q[DATA_W];
        state_d   = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      a1_q     <= '0;
      a2_q     <= '0;
      dst_q    <= '0;
      opa_q    <= '0;
      sum_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a1_q     <= a1_d;
      a2_q     <= a2_d;
      dst_q    <= dst_d;
      opa_q    <= opa_d;
      sum_q    <= sum_d;
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end

  assign result = result_q;
  assign carry  = carry_q;

endmodule

// File: tb/tb_mem_add_ctrl.sv
// tb_mem_add_ctrl
// Purpose: directed bench for mem_add_ctrl with a behavioural 8x8 synchronous
//          RAM, hand-computed expected sums and a per-cycle protocol monitor.
// Ports:   none (top-level bench)
module tb_mem_add_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] addr1, addr2, dst;
  logic [2:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       busy, done;
  logic [7:0] result;
  logic       carry;

  // Preload port for the RAM model, driven only by the bench.
  logic       tb_we;
  logic [2:0] tb_waddr;
  logic [7:0] tb_wdata;

  logic [7:0] mem [8];

  int checks;
  int fails;
  int cyc;
  logic mon_en;
  logic done_prev;

  mem_add_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .addr1     (addr1),
    .addr2     (addr2),
    .dst       (dst),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry     (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous RAM model (mem8x8): the read returns the old word.
  always @(posedge clk) begin
    if (tb_we) begin
      mem[tb_waddr] <= tb_wdata;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle. Inputs are driven and outputs are sampled 2ns after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic loadWord(input logic [2:0] a, input logic [7:0] d);
    tb_we    = 1'b1;
    tb_waddr = a;
    tb_wdata = d;
    tick();
    tb_we    = 1'b0;
  endtask

  // Issues one operation and checks every cycle of it. With hold=1, start stays
  // high and the address inputs are scrambled while busy. If those addresses were
  // latched mid-operation, the result would be wrong.
  task automatic applyStimulus(input logic [2:0] a1, input logic [2:0] a2, input logic [2:0] d,
                               input logic [8:0] exp_sum, input logic hold, output int done_cyc);
    start = 1'b1;
    addr1 = a1;
    addr2 = a2;
    dst   = d;
    tick();
    if (hold) begin
      addr1 = 3'd7;
      addr2 = 3'd7;
      dst   = 3'd5;
    end else begin
      start = 1'b0;
    end
    checkOutput("rda_busy", 32'(busy), 32'd1);
    checkOutput("rda_addr", 32'(mem_addr), 32'(a1));
    checkOutput("rda_we", 32'(mem_we), 32'd0);
    tick();
    checkOutput("rdb_addr", 32'(mem_addr), 32'(a2));
    checkOutput("rdb_done", 32'(done), 32'd0);
    tick();
    checkOutput("capb_we", 32'(mem_we), 32'd0);
    tick();
    checkOutput("wr_we", 32'(mem_we), 32'd1);
    checkOutput("wr_addr", 32'(mem_addr), 32'(d));
    checkOutput("wr_wdata", 32'(mem_wdata), 32'(exp_sum[7:0]));
    tick();
    done_cyc = cyc;
    checkOutput("done_pulse", 32'(done), 32'd1);
    checkOutput("done_we", 32'(mem_we), 32'd0);
    checkOutput("done_addr", 32'(mem_addr), 32'd0);
    checkOutput("result", 32'(result), 32'(exp_sum[7:0]));
    checkOutput("carry", 32'(carry), 32'(exp_sum[8]));
    tick();
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_done", 32'(done), 32'd0);
    checkOutput("mem_dst", 32'(mem[d]), 32'(exp_sum[7:0]));
  endtask

  // Protocol monitor, sampled on the falling edge of every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      checkOutput("mon_done_width", 32'(done && done_prev), 32'd0);
      checkOutput("mon_we_busy", 32'(mem_we && !busy), 32'd0);
      checkOutput("mon_idle_quiet", 32'(!busy && (done || mem_we || mem_addr != 3'd0)), 32'd0);
      done_prev <= done;
    end
  end

  initial begin
    int t0;
    int t1;
    checks    = 0;
    fails     = 0;
    cyc       = 0;
    mon_en    = 1'b0;
    done_prev = 1'b0;
    rst       = 1'b0;
    start     = 1'b0;
    addr1     = '0;
    addr2     = '0;
    dst       = '0;
    tb_we     = 1'b0;
    tb_waddr  = '0;
    tb_wdata  = '0;

    // Preload the RAM while the DUT is held in reset.
    for (int i = 0; i < 8; i++) loadWord(3'(i), 8'h00);
    loadWord(3'd1, 8'h12);
    loadWord(3'd2, 8'h34);
    loadWord(3'd4, 8'hF0);
    loadWord(3'd5, 8'h20);
    loadWord(3'd3, 8'h40);
    tick();

    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_we", 32'(mem_we), 32'd0);
    checkOutput("rst_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_wdata", 32'(mem_wdata), 32'd0);
    checkOutput("rst_result", 32'(result), 32'd0);
    checkOutput("rst_carry", 32'(carry), 32'd0);

    rst    = 1'b1;
    mon_en = 1'b1;
    tick();

    // 0x12 + 0x34 = 0x046 written to word 7.
    applyStimulus(3'd1, 3'd2, 3'd7, 9'h046, 1'b0, t0);
    // 0xF0 + 0x20 = 0x110: wraps to 0x10 and sets carry.
    applyStimulus(3'd4, 3'd5, 3'd6, 9'h110, 1'b0, t0);
    // Same word read twice, result written in place: 0x40 + 0x40 = 0x080.
    applyStimulus(3'd3, 3'd3, 3'd3, 9'h080, 1'b0, t0);
    // Repeat on the updated word: 0x80 + 0x80 = 0x100.
    applyStimulus(3'd3, 3'd3, 3'd3, 9'h100, 1'b0, t0);

    // start held high: back-to-back ops, and inputs that change mid-op are ignored.
    applyStimulus(3'd1, 3'd2, 3'd6, 9'h046, 1'b1, t0);
    applyStimulus(3'd4, 3'd5, 3'd0, 9'h110, 1'b1, t1);
    checkOutput("issue_interval", 32'(t1 - t0), 32'd6);
    start = 1'b0;
    tick();
    checkOutput("held_end_idle", 32'(busy), 32'd0);

    // Reset while in RD_B: the controller returns to IDLE and clears result.
    loadWord(3'd4, 8'hF0);
    start = 1'b1; addr1 = 3'd1; addr2 = 3'd2; dst = 3'd4;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checkOutput("rdb_rst_busy", 32'(busy), 32'd0);
    checkOutput("rdb_rst_result", 32'(result), 32'd0);
    checkOutput("rdb_rst_carry", 32'(carry), 32'd0);
    tick();
    tick();
    checkOutput("rdb_rst_dst", 32'(mem[4]), 32'hF0);

    // Reset while in WR: the write is cancelled immediately.
    start = 1'b1; addr1 = 3'd1; addr2 = 3'd2; dst = 3'd4;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("wr_rst_pre_we", 32'(mem_we), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("wr_rst_we_gated", 32'(mem_we), 32'd0);
    tick();
    rst = 1'b1;
    checkOutput("wr_rst_busy", 32'(busy), 32'd0);
    checkOutput("wr_rst_result", 32'(result), 32'd0);
    checkOutput("wr_rst_done", 32'(done), 32'd0);
    tick();
    tick();
    checkOutput("wr_rst_dst", 32'(mem[4]), 32'hF0);

    // A normal operation after the resets still works.
    applyStimulus(3'd1, 3'd2, 3'd5, 9'h046, 1'b0, t0);

    tick();
    mon_en = 1'b0;
    $display("[TB] %0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
